pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Generates per-operand forwarding selects that drive the EX-stage operand muxes.
- Detects load-use hazards and inserts a one-cycle bubble; freezes the pipe while data memory is not ready.
- Flushes wrong-path instructions on a taken branch or jump, and keeps saturating stall and flush counters.

Parameters:
- REG_ADDR_W, 5: register index width.
- MEM_TIMEOUT, 255: consecutive MEM_WAIT cycles after which mem_timeout_err sets.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs1_valid_id, rs2_valid_id  in  1  ID-stage source operand used
- rs1_id, rs2_id  in  REG_ADDR_W  ID-stage source indices
- rs1_valid_ex, rs2_valid_ex  in  1  EX-stage source operand used
- rs1_ex, rs2_ex  in  REG_ADDR_W  EX-stage source indices
- rd_ex, rd_mem, rd_wb  in  REG_ADDR_W  destination index per stage
- write_enable_ex, write_enable_mem, write_enable_wb  in  1  stage writes rd
- is_load_ex  in  1  EX-stage instruction is a load
- branch_taken_ex  in  1  EX resolved a taken branch/JAL/JALR
- mem_req_mem  in  1  load/store active in MEM
- mem_ready  in  1  data memory completes the MEM access this cycle
- fwd_sel_op1, fwd_sel_op2  out  2  00 register file, 01 MEM ALU result, 10 WB data
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the stage register
- bubble_ex  out  1  load a NOP into ID/EX
- bubble_wb  out  1  load a NOP into MEM/WB
- flush_id, flush_ex  out  1  clear IF/ID and ID/EX
- state_o  out  2  current FSM state
- stall_cycles, flush_count  out  CNT_W  saturating performance counters
- mem_timeout_err  out  1  sticky error flag

Behaviour:
- Reset (asynchronous): state=RUN, counters=0, mem_timeout_err=0, wait counter=0.
  - While rst is high: flush_id=flush_ex=1; all stall and bubble outputs 0; fwd_sel=00.
- Forwarding (combinational, per operand, evaluated in EX):
  - A match requires valid_ex=1, write_enable=1, rs_ex==rd and rs_ex!=0.
  - A MEM match gives 01. Otherwise a WB match gives 10. Otherwise 00.
  - MEM has priority over WB because it is the newer result.
  - x0 never forwards.
- Load-use detection (ID):
  - hazard = is_load_ex & write_enable_ex & rd_ex!=0 & ((rs1_valid_id & rs1_id==rd_ex) | (rs2_valid_id & rs2_id==rd_ex)).
- FSM states: RUN=0, LOAD_STALL=1, MEM_WAIT=2.
  - RUN, mem_req_mem & !mem_ready: go to MEM_WAIT. Same cycle: stall_if/id/ex/mem=1, bubble_wb=1.
  - RUN, else if branch_taken_ex: flush_id=flush_ex=1, flush_count++, stay in RUN. Branch beats load-use because the dependent instruction is wrong-path.
  - RUN, else if hazard: stall_if=stall_id=1, bubble_ex=1, go to LOAD_STALL.
  - LOAD_STALL: lasts exactly one cycle, no stall outputs, returns to RUN. A new hazard cannot arise here because EX holds the bubble.
    - mem_req_mem & !mem_ready in this cycle takes the MEM_WAIT path instead.
  - MEM_WAIT: stall_if/id/ex/mem=1 and bubble_wb=1 while !mem_ready.
    - On mem_ready: stalls deassert in that same cycle and the state returns to RUN.
    - A branch_taken_ex held in EX during MEM_WAIT is not flushed until the release cycle. It is then handled as in RUN, exactly once.
- Latency and output timing:
  - Hazard outputs are combinational from the registered state and the current inputs, giving zero-cycle response.
  - Load-use costs exactly one bubble.
- Counters:
  - stall_cycles increments in every cycle in which any stall_* output is 1.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Timeout:
  - The wait counter increments in MEM_WAIT and clears on leaving it.
  - Reaching MEM_TIMEOUT sets mem_timeout_err, which stays set until rst.
  - The FSM keeps waiting after the timeout.
- Reset asserted mid-stall or mid-wait returns everything to RUN immediately; no pending flush survives reset.

Decomposition:
- Package riscv_pipe_pkg holds:
  - the fwd_sel encoding (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10);
  - the state encoding (ST_RUN, ST_LOAD_STALL, ST_MEM_WAIT);
  - REG_ADDR_W.
- Sub-module hazard_fwd_select: pure combinational per-operand select, instantiated twice (op1, op2).

Test Plan:
- Forwarding priority: rs1_ex=5, MEM and WB both write x5 -> fwd_sel_op1=01. Clear write_enable_mem -> 10. Set rs1_ex=0 -> 00.
- Load-use: load x7 in EX, ID rs2_id=7 valid -> one cycle with stall_if=stall_id=bubble_ex=1, state 0->1->0, stall_cycles=1. Two cycles later the load is in WB and fwd_sel_op2=10.
- Branch over load-use: branch_taken_ex=1 and hazard in the same cycle -> flush_id=flush_ex=1, no bubble, flush_count=1.
- Memory wait: mem_req_mem=1, mem_ready=0 for 4 cycles, then 1 -> stalls high for 4 cycles and low on the ready cycle; stall_cycles=4; branch_taken_ex held throughout gives exactly one flush, on the release cycle.
- Timeout with MEM_TIMEOUT=3: mem_ready held 0 for 5 cycles -> mem_timeout_err=1 after the 3rd cycle, stays 1 after mem_ready, clears only on rst.
- Reset mid MEM_WAIT: assert rst asynchronously between edges -> stalls drop immediately, flush_id=flush_ex=1, state_o=0, counters=0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared encodings for the 5-stage RV32I pipeline control logic:
//   - register index width
//   - EX-stage operand forwarding select encoding
//   - hazard controller FSM state encoding
//   - bundled stage-control word used inside the hazard controller
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

    localparam int REG_ADDR_W = 5;

    // Operand source select for the EX-stage operand muxes
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
    localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result sitting in MEM
    localparam logic [1:0] FWD_WB  = 2'b10;  // write-back data

    // Hazard controller FSM states
    localparam logic [1:0] ST_RUN        = 2'b00;
    localparam logic [1:0] ST_LOAD_STALL = 2'b01;
    localparam logic [1:0] ST_MEM_WAIT   = 2'b10;

    // Stage-control word produced by the hazard FSM
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic bubble_ex;
        logic bubble_wb;
        logic flush_id;
        logic flush_ex;
    } ctrl_t;

    // Pipe advances freely
    localparam ctrl_t CTRL_IDLE = '{
        stall_if: 1'b0, stall_id: 1'b0, stall_ex: 1'b0, stall_mem: 1'b0,
        bubble_ex: 1'b0, bubble_wb: 1'b0, flush_id: 1'b0, flush_ex: 1'b0
    };

    // Whole pipe frozen behind a pending data-memory access
    localparam ctrl_t CTRL_MEM_HOLD = '{
        stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1, stall_mem: 1'b1,
        bubble_ex: 1'b0, bubble_wb: 1'b1, flush_id: 1'b0, flush_ex: 1'b0
    };

    // Front end held for one cycle, NOP injected into EX
    localparam ctrl_t CTRL_LOAD_USE = '{
        stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b0, stall_mem: 1'b0,
        bubble_ex: 1'b1, bubble_wb: 1'b0, flush_id: 1'b0, flush_ex: 1'b0
    };

    // Wrong-path instructions in IF/ID and ID/EX discarded
    localparam ctrl_t CTRL_FLUSH = '{
        stall_if: 1'b0, stall_id: 1'b0, stall_ex: 1'b0, stall_mem: 1'b0,
        bubble_ex: 1'b0, bubble_wb: 1'b0, flush_id: 1'b1, flush_ex: 1'b1
    };

endpackage

// File: rtl/hazard_fwd_select.sv
// -----------------------------------------------------------------------------
// hazard_fwd_select
// Combinational forwarding select for one EX-stage source operand.
// Ports:
//   rs_valid          in   operand is actually read by the EX instruction
//   rs                in   operand register index
//   rd_mem, rd_wb     in   destination index of the MEM / WB instructions
//   write_enable_mem  in   MEM instruction writes rd_mem
//   write_enable_wb   in   WB instruction writes rd_wb
//   fwd_sel           out  FWD_RF / FWD_MEM / FWD_WB
// -----------------------------------------------------------------------------
module hazard_fwd_select #(
    parameter int ADDR_W = riscv_pipe_pkg::REG_ADDR_W
) (
    input  logic              rs_valid,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rd_mem,
    input  logic              write_enable_mem,
    input  logic [ADDR_W-1:0] rd_wb,
    input  logic              write_enable_wb,
    output logic [1:0]        fwd_sel
);
    import riscv_pipe_pkg::*;

    logic rs_nonzero_s;
    logic mem_hit_s;
    logic wb_hit_s;

    // x0 is hard-wired zero, so a write to it must never be forwarded
    assign rs_nonzero_s = (rs != {ADDR_W{1'b0}});
    assign mem_hit_s    = rs_valid & rs_nonzero_s & write_enable_mem & (rs == rd_mem);
    assign wb_hit_s     = rs_valid & rs_nonzero_s & write_enable_wb  & (rs == rd_wb);

    // MEM holds the younger result, so it wins over WB
    always_comb begin
        if (mem_hit_s) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit_s) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Ports:
//   clk, rst                       clock, async active-high reset
//   rs{1,2}_valid_id, rs{1,2}_id   ID-stage source operands (load-use check)
//   rs{1,2}_valid_ex, rs{1,2}_ex   EX-stage source operands (forwarding)
//   rd_{ex,mem,wb}                 destination index per stage
//   write_enable_{ex,mem,wb}       stage writes its rd
//   is_load_ex                     EX instruction is a load
//   branch_taken_ex                EX resolved a taken branch/jump
//   mem_req_mem, mem_ready         data-memory handshake for the MEM stage
//   fwd_sel_op1, fwd_sel_op2       EX operand mux selects
//   stall_{if,id,ex,mem}           hold the stage register
//   bubble_ex, bubble_wb           NOP into ID/EX, MEM/WB
//   flush_id, flush_ex             clear IF/ID, ID/EX
//   state_o                        current FSM state
//   stall_cycles, flush_count      saturating performance counters
//   mem_timeout_err                sticky memory-timeout flag
// Control outputs are combinational from the registered state and current
// inputs so a hazard is answered in the cycle it appears.
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W  = riscv_pipe_pkg::REG_ADDR_W,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rs1_valid_id,
    input  logic                  rs2_valid_id,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_valid_ex,
    input  logic                  rs2_valid_ex,
    input  logic [REG_ADDR_W-1:0] rs1_ex,
    input  logic [REG_ADDR_W-1:0] rs2_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  write_enable_ex,
    input  logic                  write_enable_mem,
    input  logic                  write_enable_wb,
    input  logic                  is_load_ex,
    input  logic                  branch_taken_ex,
    input  logic                  mem_req_mem,
    input  logic                  mem_ready,
    output logic [1:0]            fwd_sel_op1,
    output logic [1:0]            fwd_sel_op2,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_mem,
    output logic                  bubble_ex,
    output logic                  bubble_wb,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic                  mem_timeout_err
);
    import riscv_pipe_pkg::*;

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_next_s;
    logic [CNT_W-1:0]  stall_cycles_r;
    logic [CNT_W-1:0]  flush_count_r;
    logic              timeout_err_r;

    logic [1:0]        fwd_op1_s;
    logic [1:0]        fwd_op2_s;
    logic              load_use_s;
    logic              mem_busy_s;
    logic              stall_any_s;

    ctrl_t             adv_ctrl_s;
    logic [1:0]        adv_next_s;
    logic              adv_flush_s;
    ctrl_t             ctrl_s;
    logic              flush_event_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end else begin
            return value + CNT_W'(1);
        end
    endfunction

    hazard_fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_op1 (
        .rs_valid         (rs1_valid_ex),
        .rs               (rs1_ex),
        .rd_mem           (rd_mem),
        .write_enable_mem (write_enable_mem),
        .rd_wb            (rd_wb),
        .write_enable_wb  (write_enable_wb),
        .fwd_sel          (fwd_op1_s)
    );

    hazard_fwd_select #(.ADDR_W(REG_ADDR_W)) u_fwd_op2 (
        .rs_valid         (rs2_valid_ex),
        .rs               (rs2_ex),
        .rd_mem           (rd_mem),
        .write_enable_mem (write_enable_mem),
        .rd_wb            (rd_wb),
        .write_enable_wb  (write_enable_wb),
        .fwd_sel          (fwd_op2_s)
    );

    assign load_use_s = is_load_ex & write_enable_ex & (rd_ex != {REG_ADDR_W{1'b0}}) &
                        ((rs1_valid_id & (rs1_id == rd_ex)) |
                         (rs2_valid_id & (rs2_id == rd_ex)));

    assign mem_busy_s = mem_req_mem & ~mem_ready;

    // Decision for any cycle in which the pipe is free to advance. A taken
    // branch beats load-use since the dependent instruction is wrong-path.
    // While in LOAD_STALL, EX carries the bubble, so a second bubble is never
    // issued back-to-back for the same load.
    always_comb begin
        adv_ctrl_s  = CTRL_IDLE;
        adv_next_s  = ST_RUN;
        adv_flush_s = 1'b0;
        if (branch_taken_ex) begin
            adv_ctrl_s  = CTRL_FLUSH;
            adv_flush_s = 1'b1;
        end else if (load_use_s && (state_r != ST_LOAD_STALL)) begin
            adv_ctrl_s = CTRL_LOAD_USE;
            adv_next_s = ST_LOAD_STALL;
        end else begin
            adv_ctrl_s = CTRL_IDLE;
        end
    end

    // FSM: a pending memory access freezes everything; a held branch is only
    // acted on in the release cycle, which goes through the normal decision.
    always_comb begin
        ctrl_s        = CTRL_IDLE;
        state_next_s  = ST_RUN;
        flush_event_s = 1'b0;
        case (state_r)
            ST_RUN, ST_LOAD_STALL: begin
                if (mem_busy_s) begin
                    ctrl_s       = CTRL_MEM_HOLD;
                    state_next_s = ST_MEM_WAIT;
                end else begin
                    ctrl_s        = adv_ctrl_s;
                    state_next_s  = adv_next_s;
                    flush_event_s = adv_flush_s;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    ctrl_s       = CTRL_MEM_HOLD;
                    state_next_s = ST_MEM_WAIT;
                end else begin
                    ctrl_s        = adv_ctrl_s;
                    state_next_s  = adv_next_s;
                    flush_event_s = adv_flush_s;
                end
            end
            default: begin
                ctrl_s       = CTRL_IDLE;
                state_next_s = ST_RUN;
            end
        endcase
    end

    assign stall_any_s = ctrl_s.stall_if | ctrl_s.stall_id | ctrl_s.stall_ex | ctrl_s.stall_mem;

    // Wait counter counts every cycle the MEM access is held, starting with
    // the cycle that enters MEM_WAIT; it saturates at the timeout limit.
    always_comb begin
        if (state_next_s == ST_MEM_WAIT) begin
            if (wait_cnt_r == WAIT_LIMIT) begin
                wait_cnt_next_s = wait_cnt_r;
            end else begin
                wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
            end
        end else begin
            wait_cnt_next_s = {WAIT_W{1'b0}};
        end
    end

    // State, wait counter, performance counters and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_RUN;
            wait_cnt_r     <= {WAIT_W{1'b0}};
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_count_r  <= {CNT_W{1'b0}};
            timeout_err_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            if (stall_any_s) begin
                stall_cycles_r <= sat_inc(stall_cycles_r);
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (flush_event_s) begin
                flush_count_r <= sat_inc(flush_count_r);
            end else begin
                flush_count_r <= flush_count_r;
            end
            if (wait_cnt_next_s == WAIT_LIMIT) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    // Reset forces a flush and masks stalls, bubbles and forwarding so the
    // pipe drains cleanly the moment rst rises.
    always_comb begin
        if (rst) begin
            stall_if    = 1'b0;
            stall_id    = 1'b0;
            stall_ex    = 1'b0;
            stall_mem   = 1'b0;
            bubble_ex   = 1'b0;
            bubble_wb   = 1'b0;
            flush_id    = 1'b1;
            flush_ex    = 1'b1;
            fwd_sel_op1 = FWD_RF;
            fwd_sel_op2 = FWD_RF;
        end else begin
            stall_if    = ctrl_s.stall_if;
            stall_id    = ctrl_s.stall_id;
            stall_ex    = ctrl_s.stall_ex;
            stall_mem   = ctrl_s.stall_mem;
            bubble_ex   = ctrl_s.bubble_ex;
            bubble_wb   = ctrl_s.bubble_wb;
            flush_id    = ctrl_s.flush_id;
            flush_ex    = ctrl_s.flush_ex;
            fwd_sel_op1 = fwd_op1_s;
            fwd_sel_op2 = fwd_op2_s;
        end
    end

    assign state_o         = state_r;
    assign stall_cycles    = stall_cycles_r;
    assign flush_count     = flush_count_r;
    assign mem_timeout_err = timeout_err_r;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Scenario tasks drive one pipeline cycle at a time, push the expected output
// vector into a scoreboard queue, and pop/compare it at the falling edge.
// Counters are narrowed to 4 bits so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

    localparam int AW  = 5;
    localparam int CW  = 4;
    localparam int TMO = 3;
    localparam int VW  = 15 + 2 * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rs1_valid_id, rs2_valid_id, rs1_valid_ex, rs2_valid_ex;
    logic [AW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic          write_enable_ex, write_enable_mem, write_enable_wb;
    logic          is_load_ex, branch_taken_ex, mem_req_mem, mem_ready;
    logic [1:0]    fwd_sel_op1, fwd_sel_op2, state_o;
    logic          stall_if, stall_id, stall_ex, stall_mem;
    logic          bubble_ex, bubble_wb, flush_id, flush_ex, mem_timeout_err;
    logic [CW-1:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_ADDR_W(AW), .MEM_TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .rs1_valid_id(rs1_valid_id), .rs2_valid_id(rs2_valid_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_valid_ex(rs1_valid_ex), .rs2_valid_ex(rs2_valid_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .write_enable_ex(write_enable_ex), .write_enable_mem(write_enable_mem),
        .write_enable_wb(write_enable_wb),
        .is_load_ex(is_load_ex), .branch_taken_ex(branch_taken_ex),
        .mem_req_mem(mem_req_mem), .mem_ready(mem_ready),
        .fwd_sel_op1(fwd_sel_op1), .fwd_sel_op2(fwd_sel_op2),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .bubble_ex(bubble_ex), .bubble_wb(bubble_wb),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .state_o(state_o), .stall_cycles(stall_cycles), .flush_count(flush_count),
        .mem_timeout_err(mem_timeout_err)
    );

    logic [VW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] sc_e;
    logic [CW-1:0] fc_e;

    // Expected vector: fwd1, fwd2, {stall_if,id,ex,mem}, bubble_ex, bubble_wb,
    // {flush_id,flush_ex}, state, err, stall_cycles, flush_count
    function automatic logic [VW-1:0] mk(logic [1:0] f1, logic [1:0] f2, logic [3:0] stl,
                                         logic bex, logic bwb, logic [1:0] fl,
                                         logic [1:0] st, logic err,
                                         logic [CW-1:0] sc, logic [CW-1:0] fc);
        return {f1, f2, stl, bex, bwb, fl, st, err, sc, fc};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {fwd_sel_op1, fwd_sel_op2, stall_if, stall_id, stall_ex, stall_mem,
                bubble_ex, bubble_wb, flush_id, flush_ex, state_o, mem_timeout_err,
                stall_cycles, flush_count};
    endfunction

    function automatic logic [CW-1:0] sat(logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    task automatic set_idle();
        rs1_valid_id = 1'b0; rs2_valid_id = 1'b0; rs1_id = 5'd0; rs2_id = 5'd0;
        rs1_valid_ex = 1'b0; rs2_valid_ex = 1'b0; rs1_ex = 5'd0; rs2_ex = 5'd0;
        rd_ex = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0;
        write_enable_ex = 1'b0; write_enable_mem = 1'b0; write_enable_wb = 1'b0;
        is_load_ex = 1'b0; branch_taken_ex = 1'b0; mem_req_mem = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] got, want;
        set_idle();
        rs1_valid_ex = 1'b1; rs1_ex = 5'd5; rd_mem = 5'd5; write_enable_mem = 1'b1;
        branch_taken_ex = 1'b1; mem_req_mem = 1'b1; mem_ready = 1'b0;
        rst = 1'b1;
        sc_e = '0; fc_e = '0;
        exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, sc_e, fc_e));
        @(negedge clk);
        got = observed(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL reset_hold: got %h expected %h", got, want); end
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, sc_e, fc_e));
        @(negedge clk);
        got = observed(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL reset_release: got %h expected %h", got, want); end
        @(posedge clk); #1;
    endtask

    task automatic test_forwarding();
        logic [VW-1:0] got, want;
        logic [1:0]    f1, f2;
        for (int i = 0; i < 5; i++) begin
            set_idle();
            f1 = 2'b00; f2 = 2'b00;
            case (i)
                0: begin rs1_valid_ex = 1'b1; rs1_ex = 5'd5; rd_mem = 5'd5; write_enable_mem = 1'b1;
                         rd_wb = 5'd5; write_enable_wb = 1'b1; f1 = 2'b01; end
                1: begin rs1_valid_ex = 1'b1; rs1_ex = 5'd5; rd_mem = 5'd5; write_enable_mem = 1'b0;
                         rd_wb = 5'd5; write_enable_wb = 1'b1; f1 = 2'b10; end
                2: begin rs1_valid_ex = 1'b1; rs1_ex = 5'd0; rd_mem = 5'd0; write_enable_mem = 1'b1;
                         rd_wb = 5'd0; write_enable_wb = 1'b1; f1 = 2'b00; end
                3: begin rs2_valid_ex = 1'b0; rs2_ex = 5'd9; rd_wb = 5'd9; write_enable_wb = 1'b1;
                         rd_mem = 5'd9; f2 = 2'b00; end
                4: begin rs2_valid_ex = 1'b1; rs2_ex = 5'd9; rd_wb = 5'd9; write_enable_wb = 1'b1;
                         rd_mem = 5'd9; f2 = 2'b10; end
                default: begin f1 = 2'b00; f2 = 2'b00; end
            endcase
            exp_q.push_back(mk(f1, f2, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, sc_e, fc_e));
            @(negedge clk);
            got = observed(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL fwd[%0d]: got %h expected %h", i, got, want); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic [VW-1:0] got, want;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            case (i)
                0: begin
                    is_load_ex = 1'b1; write_enable_ex = 1'b1; rd_ex = 5'd7;
                    rs2_valid_id = 1'b1; rs2_id = 5'd7;
                    exp_q.push_back(mk(2'b00, 2'b00, 4'b1100, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, sc_e, fc_e));
                end
                1: begin
                    rs2_valid_id = 1'b1; rs2_id = 5'd7; rd_mem = 5'd7; write_enable_mem = 1'b1;
                    exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, sc_e, fc_e));
                end
                default: begin
                    rs2_valid_ex = 1'b1; rs2_ex = 5'd7; rd_wb = 5'd7; write_enable_wb = 1'b1;
                    exp_q.push_back(mk(2'b00, 2'b10, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, sc_e, fc_e));
                end
            endcase
            @(negedge clk);
            got = observed(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL load_use[%0d]: got %h expected %h", i, got, want); end
            if (i == 0) sc_e = sat(sc_e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_over_load();
        logic [VW-1:0] got, want;
        for (int i = 0; i < 2; i++) begin
            set_idle();
            if (i == 0) begin
                is_load_ex = 1'b1; write_enable_ex = 1'b1; rd_ex = 5'd3;
                rs1_valid_id = 1'b1; rs1_id = 5'd3; branch_taken_ex = 1'b1;
                exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, sc_e, fc_e));
            end else begin
                exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, sc_e, fc_e));
            end
            @(negedge clk);
            got = observed(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL branch_over_load[%0d]: got %h expected %h", i, got, want); end
            if (i == 0) fc_e = sat(fc_e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [VW-1:0] got, want;
        for (int i = 0; i < 6; i++) begin
            set_idle();
            if (i <= 3) begin
                mem_req_mem = 1'b1; mem_ready = 1'b0; branch_taken_ex = 1'b1;
                exp_q.push_back(mk(2'b00, 2'b00, 4'b1111, 1'b0, 1'b1, 2'b00,
                                   (i == 0) ? 2'b00 : 2'b10, (i >= 3) ? 1'b1 : 1'b0, sc_e, fc_e));
            end else if (i == 4) begin
                mem_req_mem = 1'b1; mem_ready = 1'b1; branch_taken_ex = 1'b1;
                exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b11, 2'b10, 1'b1, sc_e, fc_e));
            end else begin
                exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, sc_e, fc_e));
            end
            @(negedge clk);
            got = observed(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL mem_wait[%0d]: got %h expected %h", i, got, want); end
            if (i <= 3) sc_e = sat(sc_e);
            if (i == 4) fc_e = sat(fc_e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [VW-1:0] got, want;
        for (int i = 0; i < 2; i++) begin
            set_idle();
            mem_req_mem = 1'b1; mem_ready = 1'b0; branch_taken_ex = 1'b1;
            exp_q.push_back(mk(2'b00, 2'b00, 4'b1111, 1'b0, 1'b1, 2'b00,
                               (i == 0) ? 2'b00 : 2'b10, 1'b1, sc_e, fc_e));
            @(negedge clk);
            got = observed(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL pre_reset_wait[%0d]: got %h expected %h", i, got, want); end
            sc_e = sat(sc_e);
            if (i == 0) begin @(posedge clk); #1; end
        end
        // assert reset between clock edges
        #2;
        rst = 1'b1;
        sc_e = '0; fc_e = '0;
        exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, sc_e, fc_e));
        #1;
        got = observed(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL async_reset: got %h expected %h", got, want); end
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, sc_e, fc_e));
        @(negedge clk);
        got = observed(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL after_async_reset: got %h expected %h", got, want); end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        logic [VW-1:0] got, want;
        for (int i = 0; i < 7; i++) begin
            set_idle();
            if (i <= 4) begin
                mem_req_mem = 1'b1; mem_ready = 1'b0;
                exp_q.push_back(mk(2'b00, 2'b00, 4'b1111, 1'b0, 1'b1, 2'b00,
                                   (i == 0) ? 2'b00 : 2'b10, (i >= 3) ? 1'b1 : 1'b0, sc_e, fc_e));
            end else if (i == 5) begin
                mem_req_mem = 1'b1; mem_ready = 1'b1;
                exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, sc_e, fc_e));
            end else begin
                exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, sc_e, fc_e));
            end
            @(negedge clk);
            got = observed(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL timeout[%0d]: got %h expected %h", i, got, want); end
            if (i <= 4) sc_e = sat(sc_e);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        sc_e = '0; fc_e = '0;
        exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, sc_e, fc_e));
        @(negedge clk);
        got = observed(); want = exp_q.pop_front(); checks++;
        if (got !== want) begin errors++; $display("FAIL timeout_cleared: got %h expected %h", got, want); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        logic [VW-1:0] got, want;
        for (int i = 0; i < 40; i++) begin
            set_idle();
            if (i < 20) begin
                mem_req_mem = 1'b1; mem_ready = 1'b0;
                exp_q.push_back(mk(2'b00, 2'b00, 4'b1111, 1'b0, 1'b1, 2'b00,
                                   (i == 0) ? 2'b00 : 2'b10, (i >= 3) ? 1'b1 : 1'b0, sc_e, fc_e));
            end else if (i == 20) begin
                mem_req_mem = 1'b1; mem_ready = 1'b1;
                exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, sc_e, fc_e));
            end else if (i < 39) begin
                branch_taken_ex = 1'b1;
                exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b11, 2'b00, 1'b1, sc_e, fc_e));
            end else begin
                exp_q.push_back(mk(2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, sc_e, fc_e));
            end
            @(negedge clk);
            got = observed(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin errors++; $display("FAIL saturation[%0d]: got %h expected %h", i, got, want); end
            if (i < 20) sc_e = sat(sc_e);
            if (i > 20 && i < 39) fc_e = sat(fc_e);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_over_load();
        test_mem_wait();
        test_reset_mid_wait();
        test_timeout();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
